// File: rtl/serial_result_receiver_if.sv
// -----------------------------------------------------------------------------
// serial_result_receiver_if
//
// Bundles the serial result link and the parallel result presentation of the
// serial_result_receiver into one connection.
//
// Signals:
//   SerEn      bit strobe from the frequency divider (one Clk-cycle pulse per bit)
//   SerValid   frame envelope (transmitter Busy), high for the whole frame
//   SerDin     serial data (transmitter Dout), MSB of {Result, Flag} first
//   ErrClr     synchronous clear of FrameErr
//   Result     result field of the last complete frame
//   Flag       flag field of the last complete frame
//   DataReady  one-cycle pulse when Result/Flag update
//   Receiving  high while a frame is partially received
//   FrameErr   sticky framing error
//   BitCnt     bits captured in the current frame (debug)
//
// Modports:
//   master  drives the serial link and ErrClr, observes the results
//   slave   the receiver itself
// -----------------------------------------------------------------------------
interface serial_result_receiver_if #(
   parameter int DATA_W = 8,
   parameter int FLAG_W = 4
) ();

   logic              SerEn;
   logic              SerValid;
   logic              SerDin;
   logic              ErrClr;
   logic [DATA_W-1:0] Result;
   logic [FLAG_W-1:0] Flag;
   logic              DataReady;
   logic              Receiving;
   logic              FrameErr;
   logic [3:0]        BitCnt;

   modport master (
      output SerEn,
      output SerValid,
      output SerDin,
      output ErrClr,
      input  Result,
      input  Flag,
      input  DataReady,
      input  Receiving,
      input  FrameErr,
      input  BitCnt
   );

   modport slave (
      input  SerEn,
      input  SerValid,
      input  SerDin,
      input  ErrClr,
      output Result,
      output Flag,
      output DataReady,
      output Receiving,
      output FrameErr,
      output BitCnt
   );

endinterface

// File: rtl/serial_result_receiver.sv
// -----------------------------------------------------------------------------
// serial_result_receiver
//
// Deserializer at the receiving end of the calculator's serial result link.
// A frame is {Result, Flag}, MSB first, one bit captured per "tick" (a Clk
// edge with SerEn=1 and SerValid=1). After the last bit the frame is presented
// in parallel together with a one-cycle DataReady pulse. Frames that end early
// (SerValid drops before the last bit) or run long (ticks after the last bit
// while SerValid is still high) set the sticky FrameErr.
//
// Ports:
//   Clk   system clock, all state changes on the rising edge
//   Rst   asynchronous reset, active-low
//   bus   serial_result_receiver_if.slave (serial inputs, ErrClr, results)
// -----------------------------------------------------------------------------
module serial_result_receiver #(
   parameter int DATA_W = 8,
   parameter int FLAG_W = 4
) (
   input logic                     Clk,
   input logic                     Rst,
   serial_result_receiver_if.slave bus
);

   localparam int         FRAME_W  = DATA_W + FLAG_W;
   // The last bit is taken straight from SerDin, so only FRAME_W-1 bits
   // ever need to be stored.
   localparam int         SHR_W    = FRAME_W - 1;
   localparam logic [3:0] LAST_CNT = 4'(FRAME_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_r,      state_s;
   logic [SHR_W-1:0]   shreg_r,      shreg_s;
   logic [3:0]         bit_cnt_r,    bit_cnt_s;
   logic [DATA_W-1:0]  result_r,     result_s;
   logic [FLAG_W-1:0]  flag_r,       flag_s;
   logic               data_ready_r, data_ready_s;
   logic               receiving_r,  receiving_s;
   logic               frame_err_r,  frame_err_s;
   logic               err_set_s;
   logic               tick_s;
   logic [FRAME_W-1:0] frame_s;

   assign tick_s  = bus.SerEn & bus.SerValid;
   assign frame_s = {shreg_r, bus.SerDin};

   // Next-state and next-register logic for the receive FSM.
   always_comb begin
      state_s      = state_r;
      shreg_s      = shreg_r;
      bit_cnt_s    = bit_cnt_r;
      result_s     = result_r;
      flag_s       = flag_r;
      data_ready_s = 1'b0;
      err_set_s    = 1'b0;

      case (state_r)
         IDLE: begin
            if (tick_s) begin
               shreg_s   = {{(SHR_W-1){1'b0}}, bus.SerDin};
               bit_cnt_s = 4'd1;
               state_s   = RECV;
            end else begin
               state_s   = IDLE;
            end
         end

         RECV: begin
            if (!bus.SerValid) begin
               // Truncated frame: drop the partial word, keep old outputs.
               err_set_s = 1'b1;
               shreg_s   = {SHR_W{1'b0}};
               bit_cnt_s = 4'd0;
               state_s   = IDLE;
            end else if (bus.SerEn) begin
               if (bit_cnt_r == LAST_CNT) begin
                  result_s     = frame_s[FRAME_W-1 -: DATA_W];
                  flag_s       = frame_s[FLAG_W-1:0];
                  data_ready_s = 1'b1;
                  shreg_s      = {SHR_W{1'b0}};
                  bit_cnt_s    = 4'd0;
                  state_s      = DONE;
               end else begin
                  shreg_s   = {shreg_r[SHR_W-2:0], bus.SerDin};
                  bit_cnt_s = bit_cnt_r + 4'd1;
               end
            end else begin
               state_s = RECV;
            end
         end

         DONE: begin
            if (!bus.SerValid) begin
               state_s = IDLE;
            end else if (bus.SerEn) begin
               // Over-long frame: the extra bit is discarded.
               err_set_s = 1'b1;
            end else begin
               state_s = DONE;
            end
         end

         default: begin
            state_s   = IDLE;
            shreg_s   = {SHR_W{1'b0}};
            bit_cnt_s = 4'd0;
         end
      endcase

      // A framing event on the same edge as ErrClr must still be reported.
      if (err_set_s) begin
         frame_err_s = 1'b1;
      end else if (bus.ErrClr) begin
         frame_err_s = 1'b0;
      end else begin
         frame_err_s = frame_err_r;
      end

      receiving_s = (state_s == RECV);
   end

   // State and output registers.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_r      <= IDLE;
         shreg_r      <= {SHR_W{1'b0}};
         bit_cnt_r    <= 4'd0;
         result_r     <= {DATA_W{1'b0}};
         flag_r       <= {FLAG_W{1'b0}};
         data_ready_r <= 1'b0;
         receiving_r  <= 1'b0;
         frame_err_r  <= 1'b0;
      end else begin
         state_r      <= state_s;
         shreg_r      <= shreg_s;
         bit_cnt_r    <= bit_cnt_s;
         result_r     <= result_s;
         flag_r       <= flag_s;
         data_ready_r <= data_ready_s;
         receiving_r  <= receiving_s;
         frame_err_r  <= frame_err_s;
      end
   end

   assign bus.Result    = result_r;
   assign bus.Flag      = flag_r;
   assign bus.DataReady = data_ready_r;
   assign bus.Receiving = receiving_r;
   assign bus.FrameErr  = frame_err_r;
   assign bus.BitCnt    = bit_cnt_r;

endmodule
